// File: rtl/synthesijer_mul_iter.sv
// Iterative shift-add multiplier retiring BPC multiplier bits per cycle.
// Produces a full 2*WIDTH product in signed or unsigned mode, using an nd/valid/busy handshake.
module synthesijer_mul_iter #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned BPC   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  input  logic             nd,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             valid
);

  localparam int unsigned N     = WIDTH / BPC;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned PW    = WIDTH + BPC;
  localparam int unsigned AW    = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [AW-1:0]    acc;
  logic [CNT_W-1:0] cnt;
  logic             neg;

  logic             last_c;
  logic             sign_c;
  logic [WIDTH-1:0] mag_a_c;
  logic [WIDTH-1:0] mag_b_c;
  logic [PW-1:0]    partial_c;
  logic [PW-1:0]    sum_c;
  logic [AW+BPC-1:0] wide_c;
  logic [AW-1:0]    acc_next_c;

  // Operand magnitudes and product sign, captured on accept
  always_comb begin
    sign_c  = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
    mag_a_c = (signed_mode && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    mag_b_c = (signed_mode && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
  end

  // Shifting accumulator: add into the top half, then retire BPC bits to the right
  always_comb begin
    last_c     = (cnt == CNT_W'(N - 1));
    partial_c  = PW'(mcand) * PW'(mplier[BPC-1:0]);
    sum_c      = PW'(acc[AW-1:WIDTH]) + partial_c;
    wide_c     = {sum_c, acc[WIDTH-1:0]};
    acc_next_c = AW'(wide_c >> BPC);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (nd) state_next = RUN;
      RUN:     if (last_c) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
      neg       <= 1'b0;
      busy      <= 1'b0;
      valid     <= 1'b0;
      result    <= '0;
      result_hi <= '0;
    end else begin
      busy  <= (state_next != IDLE);
      valid <= (state == DONE);
      unique case (state)
        IDLE: begin
          if (nd) begin
            mcand  <= mag_a_c;
            mplier <= mag_b_c;
            acc    <= '0;
            cnt    <= '0;
            neg    <= sign_c;
          end
        end
        RUN: begin
          acc    <= acc_next_c;
          mplier <= mplier >> BPC;
          cnt    <= cnt + CNT_W'(1);
        end
        DONE: {result_hi, result} <= neg ? (~acc + AW'(1)) : acc;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_synthesijer_mul_iter.sv
// Self-checking bench for synthesijer_mul_iter: directed vector table, handshake
// corner sequences, and randomized operations against a plain-arithmetic product model.
module tb_synthesijer_mul_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  always @(posedge clk) cyc++;

  // sel 0: WIDTH=64 BPC=1 ; sel 1: WIDTH=8 BPC=2 ; sel 2: WIDTH=8 BPC=4
  logic [63:0] a0, b0, r0, rh0;
  logic        sm0, nd0, busy0, v0;
  logic [7:0]  a1, b1, r1, rh1;
  logic        sm1, nd1, busy1, v1;
  logic [7:0]  a2, b2, r2, rh2;
  logic        sm2, nd2, busy2, v2;

  synthesijer_mul_iter #(.WIDTH(64), .BPC(1)) dut0 (
    .clk(clk), .reset(reset), .a(a0), .b(b0), .signed_mode(sm0), .nd(nd0),
    .busy(busy0), .result(r0), .result_hi(rh0), .valid(v0));
  synthesijer_mul_iter #(.WIDTH(8), .BPC(2)) dut1 (
    .clk(clk), .reset(reset), .a(a1), .b(b1), .signed_mode(sm1), .nd(nd1),
    .busy(busy1), .result(r1), .result_hi(rh1), .valid(v1));
  synthesijer_mul_iter #(.WIDTH(8), .BPC(4)) dut2 (
    .clk(clk), .reset(reset), .a(a2), .b(b2), .signed_mode(sm2), .nd(nd2),
    .busy(busy2), .result(r2), .result_hi(rh2), .valid(v2));

  typedef struct {
    int          sel;
    logic [63:0] a;
    logic [63:0] b;
    bit          sm;
    bit          noise;
    bit          b2b;
    int          idle;
    logic [63:0] exp_lo;
    logic [63:0] exp_hi;
  } vec_t;

  vec_t tbl[10];

  function automatic vec_t mk(int sel, logic [63:0] av, logic [63:0] bv, bit sm, bit noise,
                              bit b2b, int idle, logic [63:0] lo, logic [63:0] hi);
    vec_t v;
    v.sel = sel; v.a = av; v.b = bv; v.sm = sm; v.noise = noise;
    v.b2b = b2b; v.idle = idle; v.exp_lo = lo; v.exp_hi = hi;
    return v;
  endfunction

  function automatic int width_of(int sel);
    return (sel == 0) ? 64 : 8;
  endfunction

  function automatic int n_of(int sel);
    return (sel == 0) ? 64 : ((sel == 1) ? 4 : 2);
  endfunction

  // Exact product of sign- or zero-extended operands, truncated to 2*w bits
  function automatic logic [127:0] ref_mul(int w, logic [63:0] av, logic [63:0] bv, bit sm);
    logic [127:0] ea, eb, wmask, pmask;
    wmask = (w == 64) ? {64'd0, {64{1'b1}}} : ((128'd1 << w) - 128'd1);
    pmask = (w == 64) ? {128{1'b1}} : ((128'd1 << (2 * w)) - 128'd1);
    ea = 128'(av) & wmask;
    eb = 128'(bv) & wmask;
    if (sm && av[w-1]) ea = ea | ~wmask;
    if (sm && bv[w-1]) eb = eb | ~wmask;
    return (ea * eb) & pmask;
  endfunction

  task automatic set_in(int sel, logic [63:0] av, logic [63:0] bv, bit sm, bit ndv);
    case (sel)
      0: begin a0 = av; b0 = bv; sm0 = sm; nd0 = ndv; end
      1: begin a1 = av[7:0]; b1 = bv[7:0]; sm1 = sm; nd1 = ndv; end
      default: begin a2 = av[7:0]; b2 = bv[7:0]; sm2 = sm; nd2 = ndv; end
    endcase
  endtask

  task automatic set_nd(int sel, bit ndv);
    case (sel)
      0: nd0 = ndv;
      1: nd1 = ndv;
      default: nd2 = ndv;
    endcase
  endtask

  function automatic bit get_busy(int sel);
    return (sel == 0) ? busy0 : ((sel == 1) ? busy1 : busy2);
  endfunction

  function automatic bit get_valid(int sel);
    return (sel == 0) ? v0 : ((sel == 1) ? v1 : v2);
  endfunction

  function automatic logic [127:0] get_prod(int sel);
    if (sel == 0) return {rh0, r0};
    if (sel == 1) return 128'({rh1, r1});
    return 128'({rh2, r2});
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic chk(string name, logic [127:0] got, logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // One full operation: accept, scramble inputs while busy, check busy/valid timing
  task automatic run_op(int sel, logic [63:0] av, logic [63:0] bv, bit sm, bit noise,
                        output logic [127:0] prod, output int vcyc);
    int n = n_of(sel);
    int bad_busy = 0;
    int vcount = 0;
    int first = -1;
    @(negedge clk);
    set_in(sel, av, bv, sm, 1'b1);
    @(posedge clk); #1;
    if (!get_busy(sel)) bad_busy++;
    for (int k = 1; k <= n + 1; k++) begin
      @(negedge clk);
      set_in(sel, rnd64(), rnd64(), 1'($urandom),
             noise && get_busy(sel) && ($urandom_range(0, 1) == 1));
      @(posedge clk); #1;
      if (get_busy(sel) != (k <= n)) bad_busy++;
      if (get_valid(sel)) begin
        vcount++;
        if (first < 0) first = k;
      end
    end
    set_nd(sel, 1'b0);
    prod = get_prod(sel);
    vcyc = cyc;
    chk("busy_profile", 128'(bad_busy), 128'd0);
    chk("valid_latency", 128'(first), 128'(n + 1));
    chk("valid_count", 128'(vcount), 128'd1);
  endtask

  logic [127:0] prod, exp;
  logic [63:0]  mask, got_lo, got_hi, av, bv;
  int           vcyc, prev_vcyc, w, sel, cnt;
  bit           sm;

  initial begin
    set_in(0, 64'd0, 64'd0, 1'b0, 1'b0);
    set_in(1, 64'd0, 64'd0, 1'b0, 1'b0);
    set_in(2, 64'd0, 64'd0, 1'b0, 1'b0);
    reset = 1'b0;
    prev_vcyc = 0;

    tbl[0] = mk(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 0, 0, 0, 4, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1);
    tbl[1] = mk(0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 1, 1, 0, 0, 64'hFFFF_FFFF_FFFF_FFEB, 64'hFFFF_FFFF_FFFF_FFFF);
    tbl[2] = mk(0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1, 0, 0, 0, 64'd0, 64'h4000_0000_0000_0000);
    tbl[3] = mk(0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB, 1, 0, 0, 2, 64'd0, 64'd0);
    tbl[4] = mk(0, 64'h8000_0000_0000_0000, 64'd1, 1, 0, 0, 0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
    tbl[5] = mk(1, 64'h80, 64'h7F, 1, 1, 0, 6, 64'h80, 64'hC0);
    tbl[6] = mk(1, 64'hFF, 64'hFF, 0, 1, 0, 3, 64'h01, 64'hFE);
    tbl[7] = mk(1, 64'hFF, 64'hFF, 1, 1, 0, 2, 64'h01, 64'h00);
    tbl[8] = mk(2, 64'd15, 64'd17, 0, 0, 0, 0, 64'hFF, 64'h00);
    tbl[9] = mk(2, 64'd200, 64'd200, 0, 0, 1, 4, 64'h40, 64'h9C);

    // Reset held: requests must be ignored and all outputs stay clear
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int s = 0; s < 3; s++) set_in(s, rnd64(), rnd64(), 1'($urandom), 1'b1);
      @(posedge clk); #1;
      for (int s = 0; s < 3; s++) begin
        chk("rst_prod", get_prod(s), 128'd0);
        chk("rst_busy_valid", 128'({get_busy(s), get_valid(s)}), 128'd0);
      end
    end
    @(negedge clk);
    for (int s = 0; s < 3; s++) set_nd(s, 1'b0);
    reset = 1'b1;

    for (int i = 0; i < 10; i++) begin
      w = width_of(tbl[i].sel);
      run_op(tbl[i].sel, tbl[i].a, tbl[i].b, tbl[i].sm, tbl[i].noise, prod, vcyc);
      mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
      got_lo = 64'(prod) & mask;
      got_hi = 64'(prod >> w) & mask;
      chk($sformatf("vec%0d_lo", i), 128'(got_lo), 128'(tbl[i].exp_lo));
      chk($sformatf("vec%0d_hi", i), 128'(got_hi), 128'(tbl[i].exp_hi));
      if (tbl[i].b2b) chk("b2b_spacing", 128'(vcyc - prev_vcyc), 128'(n_of(tbl[i].sel) + 2));
      prev_vcyc = vcyc;
      if (tbl[i].idle > 0) begin
        cnt = 0;
        for (int c = 0; c < tbl[i].idle; c++) begin
          @(posedge clk); #1;
          if (get_valid(tbl[i].sel)) cnt++;
        end
        chk("no_extra_valid", 128'(cnt), 128'd0);
        chk("result_hold", get_prod(tbl[i].sel), prod);
      end
    end

    // Reset during RUN aborts the operation with no later valid
    @(negedge clk);
    set_in(1, 64'h55, 64'h33, 1'b0, 1'b1);
    @(posedge clk); #1;
    set_nd(1, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_prod", get_prod(1), 128'd0);
    chk("midrst_busy_valid", 128'({busy1, v1}), 128'd0);
    @(negedge clk);
    reset = 1'b1;
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (v1 || busy1) cnt++;
    end
    chk("midrst_quiet", 128'(cnt), 128'd0);
    run_op(1, 64'h9D, 64'h2B, 1'b1, 1'b0, prod, vcyc);
    chk("midrst_recover", prod, ref_mul(8, 64'h9D, 64'h2B, 1'b1));

    // Randomized operations with corner-biased operands
    for (int i = 0; i < 24; i++) begin
      sel = $urandom_range(0, 2);
      w = width_of(sel);
      av = rnd64();
      bv = rnd64();
      case ($urandom_range(0, 5))
        0: av = 64'd0;
        1: bv = {64{1'b1}};
        2: av = 64'd1 << (w - 1);
        3: begin av = 64'd1 << (w - 1); bv = 64'd1 << (w - 1); end
        default: ;
      endcase
      sm = 1'($urandom);
      exp = ref_mul(w, av, bv, sm);
      run_op(sel, av, bv, sm, 1'($urandom), prod, vcyc);
      chk($sformatf("rand%0d_w%0d_sm%0d", i, w, sm), prod, exp);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/synthesijer_mul_iter.md
Name: synthesijer_mul_iter

Overview:
- Parametrised, multi-cycle iterative shift-add multiplier.
- Successor to the single-cycle combinational multipliers in the synthesijer HDL library.
- Adds configurable width, configurable bits retired per cycle, a runtime signed/unsigned mode, a full double-width product, and a real nd/valid/busy handshake.
- Sits beside the other synthesijer arithmetic units. Generated schedulers drive nd, wait for valid, and read result/result_hi.

Parameters:
- WIDTH, 64, operand and result width in bits; legal values 4..128.
- BPC, 1, multiplier bits retired per RUN cycle. Must divide WIDTH; legal values 1, 2, 4.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- a  input  WIDTH  multiplicand, sampled on accept.
- b  input  WIDTH  multiplier, sampled on accept.
- signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled on accept.
- nd  input  1  new-data strobe; a request is accepted only when busy=0.
- busy  output  1  high while an operation is in flight; nd is ignored while busy=1.
- result  output  WIDTH  low WIDTH bits of the product.
- result_hi  output  WIDTH  high WIDTH bits of the 2*WIDTH product.
- valid  output  1  one-cycle pulse when result/result_hi are updated.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, busy=0, valid=0, result=0, result_hi=0; all internal registers cleared.
  - Reset asserted mid-operation aborts the operation; no valid pulse is ever produced for it.
- Let N = WIDTH/BPC. States are IDLE, RUN and DONE.
- IDLE:
  - busy=0.
  - nd=1 at edge t accepts the request:
    - sign flag = signed_mode & (a[MSB] ^ b[MSB]).
    - Capture magnitudes: |a|,|b| when signed_mode=1 (negate if MSB set); raw a,b otherwise. Held as WIDTH-bit unsigned.
    - Clear the 2*WIDTH-bit accumulator; cnt=0; next state RUN.
  - nd=0: stay in IDLE.
- RUN:
  - busy=1.
  - Each cycle, take the low BPC bits of the multiplier register and add (mcand * those bits) << (cnt*BPC) to the accumulator.
  - Alternatively, use an equivalent shifting accumulator; the result must match bit-for-bit.
  - Shift the multiplier register right by BPC; cnt++.
  - After N RUN cycles (cnt reaches N-1 and is processed), next state is DONE.
- DONE:
  - busy=1 for one cycle.
  - {result_hi,result} = sign flag ? (two's-complement negate of the accumulator, 2*WIDTH bits) : accumulator, registered at the DONE edge.
  - valid=1 for exactly this one cycle; next state IDLE.
- Timing:
  - Accept at edge t; valid is high during the cycle following edge t+N+1.
  - Latency from accept to valid is N+1 edges.
  - Minimum issue interval is N+2 cycles.
  - result/result_hi hold their value until the next DONE or reset.
- Handshake rules:
  - nd while busy=1 (RUN or DONE) is dropped silently; no queueing.
  - a, b and signed_mode may change freely after the accept edge.
  - nd in the first IDLE cycle after DONE is accepted normally, i.e. back-to-back operations.
- Arithmetic:
  - The product is exact in 2*WIDTH bits in both modes.
  - In signed mode, result equals the low WIDTH bits of the signed product, identical to a combinational a*b truncation.
  - Most-negative operand: magnitude 2^(WIDTH-1) fits unsigned WIDTH. (-2^(W-1))*(-2^(W-1)) = 2^(2W-2), which is positive and representable.
  - A zero operand gives a zero product with the sign flag ignored; negative zero cannot occur.
- busy is registered (state-decoded from flops); valid is registered.

Test Plan:
- Reset: hold reset=0, drive nd=1 with random a/b -> busy=0, valid=0, result=0, result_hi=0 throughout. Release reset; first accept behaves normally.
- WIDTH=64, BPC=1, unsigned: a=0xFFFF_FFFF_FFFF_FFFF, b=2, nd at edge 0 -> valid only in cycle after edge 65; result=0xFFFF_FFFF_FFFF_FFFE, result_hi=0x1; busy high edges 1..65.
- WIDTH=64, signed: a=-3, b=7 -> result=0xFFFF_FFFF_FFFF_FFEB, result_hi=0xFFFF_FFFF_FFFF_FFFF. Separately, a=b=0x8000_0000_0000_0000 -> result=0, result_hi=0x4000_0000_0000_0000.
- WIDTH=8, BPC=2, signed: a=0x80 (-128), b=0x7F (127) -> {result_hi,result}=0xC080; valid 5 edges after accept. nd pulses during busy are ignored, and no extra valid appears.
- Back-to-back, WIDTH=8, BPC=4, unsigned: accept 15*17, then nd in the first IDLE cycle with 200*200 -> first valid gives 0x00FF; second valid gives 0x9C40 exactly N+2=4 cycles later.
- Mid-operation reset: accept, assert reset at RUN cycle 3 -> outputs clear immediately, no valid afterwards. A new request after release completes with the correct product.
